// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-port bundle between the fetch queue and instruction memory
interface fetch_queue_if #(
    parameter int AW = 32
) ();
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF stage: PC generator, pipelined instruction requests, {pc, inst} buffer
module fetch_queue #(
    parameter int            AW         = 32,
    parameter logic [AW-1:0] RESET_PC   = 32'h1c00_0000,
    parameter int            IBUF_DEPTH = 4,
    parameter int            MAX_OUT    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          D_allowin,
    output logic          FD_valid,
    output logic [AW-1:0] FD_pc,
    output logic [31:0]   FD_inst,
    fetch_queue_if.master inst
);

    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int AIW = $clog2(IBUF_DEPTH);
    localparam int PW  = AIW + 1;

    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] cancel_q, cancel_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;

    logic [AW-1:0] pc_mem   [IBUF_DEPTH];
    logic [31:0]   inst_mem [IBUF_DEPTH];

    logic [PW-1:0] count;
    logic [31:0]   credits_used;
    logic          empty;
    logic          accept;
    logic          resp_ok;
    logic          push;
    logic          pop;
    logic [AW-1:0] br_pc;

    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign br_pc = br_target & ~AW'(3);

    // Slots already promised to live in-flight requests count against the buffer,
    // so an accepted request always has somewhere to land.
    assign credits_used = 32'(out_q) - 32'(cancel_q) + 32'(count);

    assign inst.inst_req  = rstn & ~br_taken
                          & (32'(out_q) < 32'(MAX_OUT))
                          & (credits_used < 32'(IBUF_DEPTH));
    assign inst.inst_addr = req_pc_q;

    assign accept  = inst.inst_req & inst.inst_addr_ok;
    assign resp_ok = inst.inst_data_ok & (out_q != '0);
    assign push    = resp_ok & (cancel_q == '0) & ~br_taken;

    assign FD_valid = ~empty & ~br_taken;
    assign FD_pc    = pc_mem[rd_q[AIW-1:0]];
    assign FD_inst  = inst_mem[rd_q[AIW-1:0]];
    assign pop      = FD_valid & D_allowin;

    always_comb begin
        req_pc_d  = req_pc_q;
        resp_pc_d = resp_pc_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cancel_d  = cancel_q;
        out_d     = out_q + OW'(accept) - OW'(resp_ok);
        if (br_taken) begin
            // Everything still in flight after this edge belongs to the old path.
            req_pc_d  = br_pc;
            resp_pc_d = br_pc;
            wr_d      = '0;
            rd_d      = '0;
            cancel_d  = out_q - OW'(resp_ok);
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + AW'(4);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + AW'(4);
                wr_d      = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (resp_ok && (cancel_q != '0)) begin
                cancel_d = cancel_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_pc_q  <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            cancel_q  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            cancel_q  <= cancel_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q[AIW-1:0]]   <= resp_pc_q;
            inst_mem[wr_q[AIW-1:0]] <= inst.inst_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomised bench for fetch_queue against an in-order memory model
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk;
    logic        rstn;
    logic        br_taken;
    logic [31:0] br_target;
    logic        D_allowin;
    logic        FD_valid;
    logic [31:0] FD_pc;
    logic [31:0] FD_inst;

    fetch_queue_if #(.AW(32)) ibus ();

    fetch_queue #(
        .AW(32), .RESET_PC(RPC), .IBUF_DEPTH(4), .MAX_OUT(2)
    ) dut (
        .clk(clk), .rstn(rstn), .br_taken(br_taken), .br_target(br_target),
        .D_allowin(D_allowin), .FD_valid(FD_valid), .FD_pc(FD_pc), .FD_inst(FD_inst),
        .inst(ibus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        acc_s = 1'b0;
    logic        dok_s = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_addr = RPC;
    int          pops = 0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a3c_0f96;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory: responses strictly in request order, each no earlier than its due cycle.
    always @(negedge clk) begin
        if (rstn && mq.size() > 0 && mq[0].due <= cyc) begin
            ibus.inst_data_ok = 1'b1;
            ibus.inst_rdata   = mdata(mq[0].addr);
        end else begin
            ibus.inst_data_ok = 1'b0;
            ibus.inst_rdata   = '0;
        end
    end

    always @(posedge clk) begin
        mreq_t r;
        if (!rstn) begin
            mq.delete();
        end else begin
            if (dok_s) void'(mq.pop_front());
            if (acc_s) begin
                r.addr = acc_addr;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                mq.push_back(r);
            end
        end
        cyc++;
    end

    // Stream monitor: request addresses and popped entries must follow the PC from the last redirect.
    always @(negedge clk) begin
        #3;
        acc_s = 1'b0;
        dok_s = 1'b0;
        if (!rstn) begin
            exp_pc   = RPC;
            exp_addr = RPC;
        end else begin
            dok_s = ibus.inst_data_ok;
            if (ibus.inst_req) chk("credit_out", 32'(mq.size() < 2), 32'd1);
            if (br_taken) chk("br_noreq", 32'(ibus.inst_req), 32'd0);
            if (ibus.inst_req && ibus.inst_addr_ok) begin
                chk("req_addr", ibus.inst_addr, exp_addr);
                acc_s    = 1'b1;
                acc_addr = ibus.inst_addr;
                exp_addr = exp_addr + 32'd4;
            end
            if (FD_valid && D_allowin) begin
                chk("fd_pc", FD_pc, exp_pc);
                chk("fd_inst", FD_inst, mdata(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (br_taken) begin
                exp_pc   = br_target & ~32'h3;
                exp_addr = br_target & ~32'h3;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int p0;
        logic cond;
        rstn      = 1'b1;
        br_taken  = 1'b0;
        br_target = '0;
        D_allowin = 1'b0;
        ibus.inst_addr_ok = 1'b1;
        #2 rstn = 1'b0;

        // Reset state, then steady 1-cycle memory stream.
        repeat (3) step();
        #1;
        chk("rst_fdvalid", 32'(FD_valid), 32'd0);
        chk("rst_req", 32'(ibus.inst_req), 32'd0);
        step();
        rstn = 1'b1;
        D_allowin = 1'b1;
        #1;
        chk("t1_req", 32'(ibus.inst_req), 32'd1);
        chk("t1_addr", ibus.inst_addr, RPC);
        repeat (4) step();
        p0 = pops;
        repeat (10) step();
        chk("t1_throughput", 32'(pops - p0), 32'd10);

        // Decode stall fills exactly IBUF_DEPTH entries, then they drain in order.
        D_allowin = 1'b0;
        repeat (10) step();
        #1;
        chk("t2_full_req", 32'(ibus.inst_req), 32'd0);
        chk("t2_full_fdvalid", 32'(FD_valid), 32'd1);
        ibus.inst_addr_ok = 1'b0;
        D_allowin = 1'b1;
        p0 = pops;
        repeat (8) step();
        chk("t2_drained", 32'(pops - p0), 32'd4);
        #1;
        chk("t2_empty", 32'(FD_valid), 32'd0);
        ibus.inst_addr_ok = 1'b1;

        // Redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        cond = 1'b0;
        for (int i = 0; i < 50 && !cond; i++) begin
            step();
            cond = (mq.size() == 2) && !ibus.inst_data_ok;
        end
        chk("t3_two_out", 32'(cond), 32'd1);
        br_taken  = 1'b1;
        br_target = 32'h1c00_0103;
        #1;
        chk("t3_br_fdvalid", 32'(FD_valid), 32'd0);
        chk("t3_br_req", 32'(ibus.inst_req), 32'd0);
        step();
        br_taken = 1'b0;
        #1;
        for (int i = 0; i < 20 && !ibus.inst_req; i++) begin step(); #1; end
        chk("t3_req", 32'(ibus.inst_req), 32'd1);
        chk("t3_addr", ibus.inst_addr, 32'h1c00_0100);
        for (int i = 0; i < 20 && !FD_valid; i++) begin step(); #1; end
        chk("t3_fd_pc", FD_pc, 32'h1c00_0100);

        // Redirect coincident with a response and a pop request.
        lat_min = 2; lat_max = 2;
        D_allowin = 1'b0;
        cond = 1'b0;
        for (int i = 0; i < 60 && !cond; i++) begin
            step();
            cond = FD_valid && ibus.inst_data_ok && (mq.size() == 2);
        end
        chk("t4_setup", 32'(cond), 32'd1);
        br_taken  = 1'b1;
        br_target = 32'h1c00_0200;
        D_allowin = 1'b1;
        #1;
        chk("t4_br_fdvalid", 32'(FD_valid), 32'd0);
        step();
        br_taken = 1'b0;
        #1;
        for (int i = 0; i < 20 && !FD_valid; i++) begin step(); #1; end
        chk("t4_fd_pc", FD_pc, 32'h1c00_0200);
        chk("t4_fd_inst", FD_inst, mdata(32'h1c00_0200));

        // Asynchronous reset mid-cycle with buffered entries and two requests in flight.
        lat_min = 3; lat_max = 3;
        D_allowin = 1'b0;
        cond = 1'b0;
        for (int i = 0; i < 60 && !cond; i++) begin
            step();
            cond = FD_valid && (mq.size() == 2);
        end
        chk("t5_setup", 32'(cond), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("t5_async_fdvalid", 32'(FD_valid), 32'd0);
        chk("t5_async_req", 32'(ibus.inst_req), 32'd0);
        step();
        step();
        rstn = 1'b1;
        D_allowin = 1'b1;
        #1;
        chk("t5_restart_req", 32'(ibus.inst_req), 32'd1);
        chk("t5_restart_addr", ibus.inst_addr, RPC);
        for (int i = 0; i < 20 && !FD_valid; i++) begin step(); #1; end
        chk("t5_fd_pc", FD_pc, RPC);

        // Random latency, stalls, backpressure and redirects.
        lat_min = 1; lat_max = 5;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            step();
            D_allowin         = ($urandom_range(0, 1) != 0);
            ibus.inst_addr_ok = ($urandom_range(0, 3) != 0);
            br_taken          = ($urandom_range(0, 31) == 0);
            br_target         = $urandom;
        end
        step();
        br_taken = 1'b0;
        chk("t6_progress", 32'((pops - p0) > 100), 32'd1);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
